// File: rtl/pwm_gen_pkg.sv
// pwm_gen_pkg: shared width default, FSM states and saturating step helpers
package pwm_gen_pkg;
    localparam int CW_DEF = 10;
    typedef enum logic {IDLE, RUN} state_t;
    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max);
        return v >= max ? max : v + 32'd1;
    endfunction
    function automatic int unsigned sat_dec(input int unsigned v);
        return v == 32'd0 ? 32'd0 : v - 32'd1;
    endfunction
endpackage

// File: rtl/pwm_gen_if.sv
// pwm_gen_if: GVIO control probes into the PWM core and its readback
interface pwm_gen_if import pwm_gen_pkg::*; #(parameter int CW = CW_DEF);
    logic pwm_en, up, down, initial_update, duty_cycle_update;
    logic [CW-1:0] initial_cycle, initial_duty_cycle, duty_cycle;
    logic pwm_o, period_end_o;
    logic [CW-1:0] cur_cycle_o, cur_duty_o;
    modport master (
        output pwm_en, up, down, initial_update, duty_cycle_update,
        output initial_cycle, initial_duty_cycle, duty_cycle,
        input pwm_o, period_end_o, cur_cycle_o, cur_duty_o
    );
    modport slave (
        input pwm_en, up, down, initial_update, duty_cycle_update,
        input initial_cycle, initial_duty_cycle, duty_cycle,
        output pwm_o, period_end_o, cur_cycle_o, cur_duty_o
    );
endinterface

// File: rtl/pwm_edge_det.sv
// pwm_edge_det: one-cycle pulse on each rising edge of a level input
module pwm_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);
    logic prev;
    always_ff @(posedge clk or posedge rst)
        if (rst) prev <= 1'b0;
        else prev <= d;
    assign pulse = d & ~prev;
endmodule

// File: rtl/pwm_gen_core.sv
// pwm_gen_core: PWM generator with double-buffered period/duty applied at period wrap
module pwm_gen_core import pwm_gen_pkg::*; #(parameter int CW = CW_DEF) (
    input logic pclk,
    input logic rst,
    pwm_gen_if.slave bus
);
    localparam int unsigned MAXV = (32'd1 << CW) - 32'd1;
    logic up_p, dn_p, iu_p, du_p;
    pwm_edge_det u_up (.clk(pclk), .rst(rst), .d(bus.up), .pulse(up_p));
    pwm_edge_det u_dn (.clk(pclk), .rst(rst), .d(bus.down), .pulse(dn_p));
    pwm_edge_det u_iu (.clk(pclk), .rst(rst), .d(bus.initial_update), .pulse(iu_p));
    pwm_edge_det u_du (.clk(pclk), .rst(rst), .d(bus.duty_cycle_update), .pulse(du_p));
    state_t state;
    logic [CW-1:0] cnt, cur_cycle, cur_duty, sh_cycle, sh_duty;
    logic [CW-1:0] cap_duty, base, sh_cycle_n, sh_duty_n;
    logic pend_cycle, pend_duty, pwm, period_end, step, wrap, load;
    // duty_cycle_update wins over initial_update for the duty shadow; steps stack on top
    assign cap_duty = du_p ? bus.duty_cycle : iu_p ? bus.initial_duty_cycle : sh_duty;
    assign base = (pend_duty | du_p | iu_p) ? cap_duty : cur_duty;
    assign step = up_p ^ dn_p;
    assign sh_duty_n = !step ? cap_duty : up_p ? CW'(sat_inc(32'(base), MAXV)) : CW'(sat_dec(32'(base)));
    assign sh_cycle_n = iu_p ? bus.initial_cycle : sh_cycle;
    assign wrap = state == RUN && cur_cycle != '0 && cnt == cur_cycle - CW'(1);
    // a zero period never wraps, so shadows load directly to avoid a deadlock
    assign load = state == IDLE || cur_cycle == '0 || wrap;
    always_ff @(posedge pclk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            cur_cycle <= '0;
            cur_duty <= '0;
            sh_cycle <= '0;
            sh_duty <= '0;
            pend_cycle <= 1'b0;
            pend_duty <= 1'b0;
            pwm <= 1'b0;
            period_end <= 1'b0;
        end else begin
            sh_cycle <= sh_cycle_n;
            sh_duty <= sh_duty_n;
            pend_cycle <= (pend_cycle & ~load) | iu_p;
            pend_duty <= (pend_duty & ~load) | iu_p | du_p | step;
            if (load && pend_cycle) cur_cycle <= sh_cycle;
            if (load && pend_duty) cur_duty <= sh_duty;
            if (state == IDLE || !bus.pwm_en) begin
                state <= bus.pwm_en ? RUN : IDLE;
                cnt <= '0;
                pwm <= 1'b0;
                period_end <= 1'b0;
            end else begin
                cnt <= (wrap || cur_cycle == '0) ? '0 : cnt + CW'(1);
                period_end <= wrap;
                pwm <= cur_cycle != '0 && cnt < cur_duty;
            end
        end
    assign bus.pwm_o = pwm;
    assign bus.period_end_o = period_end;
    assign bus.cur_cycle_o = cur_cycle;
    assign bus.cur_duty_o = cur_duty;
endmodule

// File: doc/pwm_gen_core.md
Name: pwm_gen_core

Overview:
- PWM generator that consumes the GVIO control probes: pwm_en, up/down stepping, initial period/duty load, direct duty update.
- Produces a single PWM output plus readback of the active period and duty; the readback feeds GVIO probe inputs and the bench.
- Lives in the pclk domain beside the GVIO instance. Period and duty changes are double-buffered and take effect only at period boundaries.

Parameters:
- CW, 10, width of the period, duty and counter fields.

Ports:
- pclk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- pwm_en  input  1  level; 1 = run, 0 = stop and hold output low
- up  input  1  level; each rising edge requests active duty +1
- down  input  1  level; each rising edge requests active duty -1
- initial_cycle  input  CW  period value in pclk cycles
- initial_duty_cycle  input  CW  duty paired with initial_cycle
- initial_update  input  1  level; rising edge captures initial_cycle and initial_duty_cycle into the shadow registers
- duty_cycle_update  input  1  level; rising edge captures duty_cycle into the shadow duty
- duty_cycle  input  CW  direct duty value
- pwm_o  output  1  PWM waveform, registered
- cur_cycle_o  output  CW  active period
- cur_duty_o  output  CW  active duty
- period_end_o  output  1  one-cycle pulse on the counter wrap

Behaviour:
- Reset is asynchronous on rst=1. All registers clear:
  - pwm_o=0, cur_cycle_o=0, cur_duty_o=0, period_end_o=0;
  - counter=0, shadows=0, pending flags=0, edge-history regs=0;
  - state=IDLE.
- Edge detection:
  - up, down, initial_update and duty_cycle_update each have a history register; pulse = in & ~prev.
  - A level held high produces exactly one pulse.
- Shadow registers:
  - initial_update pulse: sh_cycle<=initial_cycle, sh_duty<=initial_duty_cycle, pend_cycle<=1, pend_duty<=1.
  - duty_cycle_update pulse: sh_duty<=duty_cycle, pend_duty<=1.
  - Both pulses in the same cycle: sh_cycle comes from initial_cycle; sh_duty comes from duty_cycle (duty_cycle_update has priority for duty).
- Step requests:
  - up/down pulses act on the step target: sh_duty if pend_duty=1, otherwise cur_duty_o. The result is written to sh_duty and sets pend_duty.
  - up saturates at 2^CW-1; down saturates at 0.
  - up and down in the same cycle: no change.
  - A step arriving in the same cycle as an update pulse is applied on top of the newly captured value.
- State machine:
  - IDLE: counter=0, pwm_o=0. Pending shadows are applied immediately (cur_*<=sh_*, flags cleared). Go to RUN when pwm_en=1.
  - RUN: counter increments each cycle. When counter==cur_cycle_o-1, counter<=0, period_end_o=1 next cycle, and any pending shadows load into cur_* on that same edge. pwm_en=0 returns to IDLE on the next edge: pwm_o<=0, counter<=0.
- Output:
  - pwm_o<=(counter<cur_duty_o) in RUN, registered, so one cycle of latency after the counter.
  - Every period is a full cur_cycle_o cycles long, with high time = min(cur_duty_o, cur_cycle_o).
- Boundaries:
  - cur_cycle_o=0: counter held at 0, pwm_o=0, no period_end_o. Pending shadows load immediately while cycle=0, so the design cannot deadlock.
  - cur_cycle_o=1: counter stays at 0, period_end_o asserts every cycle.
  - duty>=cycle: pwm_o constant 1. duty=0: pwm_o constant 0.
  - A new cycle value never truncates the running period; it applies at the wrap.
  - rst asserted mid-period: immediate clear regardless of state.

Decomposition:
- Package pwm_gen_pkg holds CW_DEF=10, the state enum {IDLE, RUN} and the saturating inc/dec functions.
- One sub-module, pwm_edge_det: a rising-edge detector, instantiated 4 times.
- Counter, shadow logic and FSM stay in pwm_gen_core.

Test Plan:
- Reset, then initial_cycle=10, initial_duty_cycle=3, initial_update rise, pwm_en=1 -> cur_cycle_o=10, cur_duty_o=3; pwm_o repeats 3 high/7 low; period_end_o pulses every 10 cycles.
- Mid-period (counter=4) duty_cycle=7, duty_cycle_update rise -> current period keeps 3 high; from the next wrap onward pwm_o is 7 high/3 low; cur_duty_o changes on the wrap edge.
- up held high for 20 cycles with duty=3 -> exactly one step; duty=4 from the next period. down pulses at duty=0 -> stays 0. up and down rising in the same cycle -> no change.
- duty=12 with cycle=10 -> pwm_o constant 1. initial_cycle=0 load -> pwm_o=0, no period_end_o; a later cycle=5 load applies immediately.
- initial_update and duty_cycle_update rising in the same cycle (initial_duty=2, duty_cycle=6) -> at the wrap cur_cycle_o=initial_cycle and cur_duty_o=6.
- rst pulse while RUN at counter=6 -> all outputs 0 asynchronously; with pwm_en=1 the core re-enters RUN one edge after release, with cycle=0 and output held low.
